// File: rtl/aes_pkg.sv
// Shared AES definitions: field polynomial, affine constants and GF(2^8) multiply.
package aes_pkg;

  localparam logic [8:0] AES_POLY      = 9'h11B;
  localparam logic [7:0] SBOX_AFFINE_C = 8'h63;
  localparam logic [7:0] INV_AFFINE_C  = 8'h05;

  typedef logic [7:0] aes_byte_t;

  // Shift-and-add multiply, reducing by the AES polynomial after each shift.
  function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
    aes_byte_t p;
    aes_byte_t x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ AES_POLY[7:0]) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

endpackage

// File: rtl/gf256_inv.sv
// Combinational multiplicative inverse in GF(2^8) as a^254; 0 maps to 0 naturally.
module gf256_inv
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  aes_byte_t sq;
  aes_byte_t acc;

  // a^254 = a^2 * a^4 * ... * a^128
  always_comb begin
    sq  = a;
    acc = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    y = acc;
  end

endmodule

// File: rtl/aes_sbox.sv
// AES SubBytes / InvSubBytes for one byte, registered output, one result per clock.
module aes_sbox
  import aes_pkg::*;
#(
  parameter int unsigned INVERSE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] istate,
  output logic [7:0] ostate
);

  function automatic aes_byte_t affine_fwd(input aes_byte_t b);
    aes_byte_t o;
    o = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      o[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8]
           ^ b[(i + 7) % 8] ^ SBOX_AFFINE_C[i];
    end
    return o;
  endfunction

  function automatic aes_byte_t affine_inv(input aes_byte_t x);
    aes_byte_t o;
    o = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      o[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8] ^ INV_AFFINE_C[i];
    end
    return o;
  endfunction

  aes_byte_t inv_in;
  aes_byte_t inv_out;
  aes_byte_t sub;

  gf256_inv u_gf256_inv (
    .a (inv_in),
    .y (inv_out)
  );

  // One shared inverter: the affine step sits after it for the forward box, before it for the inverse box.
  always_comb begin
    inv_in = (INVERSE != 0) ? affine_inv(istate) : istate;
    sub    = (INVERSE != 0) ? inv_out : affine_fwd(inv_out);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ostate <= '0;
    else        ostate <= sub;
  end

endmodule

// File: tb/tb_aes_sbox.sv
// Scoreboarded bench: forward, inverse and four-wide SubWord instances against a table model.
module tb_aes_sbox;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  f_in, f_out;
  logic [7:0]  i_drv, i_in, i_out;
  logic [31:0] w_in, w_out;
  logic        chain_sel;

  always #5 clk = ~clk;

  assign i_in = chain_sel ? f_out : i_drv;

  aes_sbox #(.INVERSE(0)) u_fwd (.clk(clk), .rst_n(rst_n), .istate(f_in), .ostate(f_out));
  aes_sbox #(.INVERSE(1)) u_inv (.clk(clk), .rst_n(rst_n), .istate(i_in), .ostate(i_out));

  for (genvar g = 0; g < 4; g++) begin : g_word
    aes_sbox #(.INVERSE(0)) u_sb (
      .clk(clk), .rst_n(rst_n), .istate(w_in[8*g +: 8]), .ostate(w_out[8*g +: 8])
    );
  end

  typedef struct {
    bit          cf; logic [7:0]  ef;
    bit          ci; logic [7:0]  ei;
    bit          cw; logic [31:0] ew;
    bit          cr; logic [31:0] er;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  sb[256];
  logic [7:0]  isb[256];
  logic [7:0]  last_f = 8'h00;

  // Reference model: schoolbook field multiply, brute-force inverse, rotate-based affine map.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    int unsigned p, aa;
    p  = 0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa << 1;
      if ((aa & 32'h100) != 0) aa = aa ^ 32'h11B;
    end
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic exp_t mk(input bit cf, input logic [7:0] ef, input bit ci,
                              input logic [7:0] ei, input bit cw, input logic [31:0] ew);
    exp_t e;
    e.cf = cf; e.ef = ef; e.ci = ci; e.ei = ei;
    e.cw = cw; e.ew = ew; e.cr = 1'b0; e.er = '0;
    return e;
  endfunction

  task automatic step(input bit rv, input logic [7:0] f, input logic [7:0] iv,
                      input logic [31:0] w, input bit ch, input exp_t e);
    @(negedge clk);
    rst_n     = rv;
    f_in      = f;
    i_drv     = iv;
    w_in      = w;
    chain_sel = ch;
    last_f    = f;
    if (!rv) begin
      e.ef = '0; e.ei = '0; e.ew = '0;
    end
    q.push_back(e);
  endtask

  // Monitor: every result is due one edge after its stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.cf) begin
          n_vec++;
          if (f_out !== e.ef) begin
            n_err++;
            $display("FAIL fwd: got %02h expected %02h", f_out, e.ef);
          end
        end
        if (e.ci) begin
          n_vec++;
          if (i_out !== e.ei) begin
            n_err++;
            $display("FAIL inv: got %02h expected %02h", i_out, e.ei);
          end
        end
        if (e.cw) begin
          n_vec++;
          if (w_out !== e.ew) begin
            n_err++;
            $display("FAIL subword: got %08h expected %08h", w_out, e.ew);
          end
        end
        if (e.cr) begin
          n_vec++;
          if ((w_out ^ 32'h01000000) !== e.er) begin
            n_err++;
            $display("FAIL rcon: got %08h expected %08h", w_out ^ 32'h01000000, e.er);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached with %0d checks pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fv_in[6]  = '{8'h00, 8'h01, 8'h10, 8'h53, 8'hC9, 8'hFF};
    logic [7:0] fv_out[6] = '{8'h63, 8'h7C, 8'hCA, 8'hED, 8'hDD, 8'h16};
    logic [7:0] iv_in[5]  = '{8'h63, 8'h7C, 8'hED, 8'h16, 8'h00};
    logic [7:0] iv_out[5] = '{8'h00, 8'h01, 8'h53, 8'hFF, 8'h52};
    logic [7:0]  x, y, inv, prev;
    logic [31:0] w;
    exp_t        e;

    for (int a = 0; a < 256; a++) begin
      x   = a[7:0];
      inv = 8'h00;
      if (a != 0)
        for (int b = 1; b < 256; b++)
          if (m_mul(x, b[7:0]) == 8'h01) inv = b[7:0];
      sb[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) isb[sb[a]] = a[7:0];

    rst_n = 1'b0; f_in = 8'h53; i_drv = 8'h63; w_in = 32'hCF4F3C09; chain_sel = 1'b0;

    // Reset held two cycles, then release with 53 still applied.
    repeat (2) step(1'b0, 8'h53, 8'h63, 32'hCF4F3C09, 1'b0, mk(1, 0, 1, 0, 1, 0));
    e    = mk(1, 8'hED, 1, 8'h00, 1, 32'h8A84EB01);
    e.cr = 1'b1;
    e.er = 32'h8B84EB01;
    step(1'b1, 8'h53, 8'h63, 32'hCF4F3C09, 1'b0, e);

    for (int i = 0; i < 6; i++) begin
      x = (i < 5) ? iv_in[i] : 8'h63;
      y = (i < 5) ? iv_out[i] : 8'h00;
      w = {4{fv_in[i]}};
      step(1'b1, fv_in[i], x, w, 1'b0, mk(1, fv_out[i], 1, y, 1, {4{fv_out[i]}}));
    end

    for (int a = 0; a < 256; a++) begin
      x = a[7:0];
      w = {x, ~x, x ^ 8'h5A, x + 8'h11};
      step(1'b1, x, x, w, 1'b0, mk(1, sb[a], 1, isb[a], 1, subw(w)));
    end

    // Second sweep with a one-cycle reset pulse in the middle.
    for (int a = 0; a < 256; a++) begin
      x = a[7:0];
      step(a != 128, x, ~x, {4{x}}, 1'b0, mk(1, sb[x], 1, isb[~x], 1, subw({4{x}})));
    end

    for (int n = 0; n < 200; n++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      w = $urandom;
      step(1'b1, x, y, w, 1'b0, mk(1, sb[x], 1, isb[y], 1, subw(w)));
    end

    // Inverse box fed straight from the forward box: InvS(S(x)) must return x a cycle later.
    for (int a = 0; a < 256; a++) begin
      x    = a[7:0];
      prev = last_f;
      step(1'b1, x, 8'h00, 32'h0, 1'b1, mk(1, sb[x], 1, prev, 1, 32'h63636363));
    end
    prev = last_f;
    step(1'b1, 8'h00, 8'h00, 32'h0, 1'b1, mk(1, 8'h63, 1, prev, 1, 32'h63636363));

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
